// File: rtl/table_move_arbiter.sv
// Round-robin owner of the slide-table stepper driver for two move requesters.
// Sequences homing and move pulses, times the settle windows, and homes the table on abort.
module table_move_arbiter #(
   parameter int HOME_CYCLES = 500_000_000,
   parameter int MOVE_CYCLES = 500_000_000,
   parameter int DEST_W      = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic [DEST_W-1:0] dest0,
   input  logic              home0,
   output logic              ack0,
   output logic              done0,
   input  logic              req1,
   input  logic [DEST_W-1:0] dest1,
   input  logic              home1,
   output logic              ack1,
   output logic              done1,
   input  logic              abort,
   output logic              err,
   output logic              busy,
   output logic              table_start,
   output logic              table_back,
   output logic [DEST_W-1:0] table_dest,
   output logic [DEST_W-1:0] pos,
   output logic              pos_valid
);

   localparam logic [31:0] LP_HOME_TC = 32'(HOME_CYCLES - 1);
   localparam logic [31:0] LP_MOVE_TC = 32'(MOVE_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HOME_PULSE,
      S_HOME_WAIT,
      S_MOVE_PULSE,
      S_MOVE_WAIT,
      S_FINISH
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [31:0]       r_cnt;
   logic              r_last;
   logic              r_id;
   logic              r_aborting;
   logic              r_pos_valid;
   logic              r_start;
   logic              r_back;
   logic [DEST_W-1:0] r_dest;
   logic [DEST_W-1:0] r_table_dest;
   logic [DEST_W-1:0] r_pos;

   logic              w_gnt_id;
   logic              w_take;
   logic              w_sel_home;
   logic [DEST_W-1:0] w_sel_dest;
   logic              w_abort_hit;
   logic              w_home_tc;
   logic              w_move_tc;

   always_comb begin
      w_gnt_id = 1'b0;
      if (req0 && req1) begin
         w_gnt_id = ~r_last;
      end else if (req1) begin
         w_gnt_id = 1'b1;
      end
   end

   assign w_take     = (r_state == S_IDLE) && (req0 || req1) && !abort;
   assign w_sel_dest = w_gnt_id ? dest1 : dest0;
   assign w_sel_home = w_gnt_id ? home1 : home0;
   assign w_home_tc  = (r_cnt == LP_HOME_TC);
   assign w_move_tc  = (r_cnt == LP_MOVE_TC);

   // abort recovery homing runs to completion once started
   assign w_abort_hit = abort && !r_aborting &&
                        (r_state == S_HOME_PULSE || r_state == S_HOME_WAIT ||
                         r_state == S_MOVE_PULSE || r_state == S_MOVE_WAIT);

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (w_take) begin
               if (w_sel_home || !r_pos_valid) begin
                  w_next = S_HOME_PULSE;
               end else if (w_sel_dest == r_pos) begin
                  w_next = S_FINISH;
               end else begin
                  w_next = S_MOVE_PULSE;
               end
            end
         end
         S_HOME_PULSE: w_next = S_HOME_WAIT;
         S_HOME_WAIT: begin
            if (w_home_tc) begin
               if (r_aborting || r_dest == '0) begin
                  w_next = S_FINISH;
               end else begin
                  w_next = S_MOVE_PULSE;
               end
            end
         end
         S_MOVE_PULSE: w_next = S_MOVE_WAIT;
         S_MOVE_WAIT: begin
            if (w_move_tc) begin
               w_next = S_FINISH;
            end
         end
         S_FINISH: w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
      // a back pulse just issued already starts the homing run
      if (w_abort_hit && r_state != S_HOME_PULSE) begin
         w_next = S_HOME_PULSE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_last       <= 1'b1;
         r_id         <= 1'b0;
         r_aborting   <= 1'b0;
         r_pos_valid  <= 1'b0;
         r_start      <= 1'b1;
         r_back       <= 1'b1;
         r_dest       <= '0;
         r_table_dest <= '0;
         r_pos        <= '0;
      end else begin
         r_state <= w_next;
         r_start <= (w_next != S_MOVE_PULSE);
         r_back  <= (w_next != S_HOME_PULSE);
         if (r_state == S_HOME_WAIT || r_state == S_MOVE_WAIT) begin
            r_cnt <= r_cnt + 32'd1;
         end else begin
            r_cnt <= '0;
         end
         if (w_take) begin
            r_id   <= w_gnt_id;
            r_last <= w_gnt_id;
            r_dest <= w_sel_dest;
         end
         if (w_next == S_MOVE_PULSE) begin
            r_table_dest <= (r_state == S_IDLE) ? w_sel_dest : r_dest;
         end
         if (w_abort_hit) begin
            r_aborting <= 1'b1;
         end else if (r_state == S_FINISH) begin
            r_aborting <= 1'b0;
         end
         if (w_abort_hit || (abort && r_state == S_IDLE)) begin
            r_pos_valid <= 1'b0;
         end else if (r_state == S_HOME_WAIT && w_home_tc) begin
            r_pos       <= '0;
            r_pos_valid <= 1'b1;
         end else if (r_state == S_MOVE_WAIT && w_move_tc) begin
            r_pos       <= r_table_dest;
            r_pos_valid <= 1'b1;
         end
      end
   end

   assign ack0        = w_take && !w_gnt_id;
   assign ack1        = w_take && w_gnt_id;
   assign done0       = (r_state == S_FINISH) && !r_id;
   assign done1       = (r_state == S_FINISH) && r_id;
   assign err         = (r_state == S_FINISH) && r_aborting;
   assign busy        = (r_state != S_IDLE);
   assign table_start = r_start;
   assign table_back  = r_back;
   assign table_dest  = r_table_dest;
   assign pos         = r_pos;
   assign pos_valid   = r_pos_valid;

endmodule

// File: tb/tb_table_move_arbiter.sv
// Bench for table_move_arbiter: a schedule-based model checked every cycle,
// plus directed scenarios with hand-computed timing.
module tb_table_move_arbiter;

   localparam int H = 20;
   localparam int M = 30;
   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         req0 = 1'b0, req1 = 1'b0;
   logic [W-1:0] dest0 = '0, dest1 = '0;
   logic         home0 = 1'b0, home1 = 1'b0;
   logic         abort = 1'b0;
   logic         ack0, ack1, done0, done1, err, busy;
   logic         table_start, table_back, pos_valid;
   logic [W-1:0] table_dest, pos;

   table_move_arbiter #(
      .HOME_CYCLES(H),
      .MOVE_CYCLES(M),
      .DEST_W(W)
   ) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .dest0(dest0), .home0(home0), .ack0(ack0), .done0(done0),
      .req1(req1), .dest1(dest1), .home1(home1), .ack1(ack1), .done1(done1),
      .abort(abort), .err(err), .busy(busy),
      .table_start(table_start), .table_back(table_back),
      .table_dest(table_dest), .pos(pos), .pos_valid(pos_valid)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // model: each transaction becomes a set of absolute event cycles
   bit           m_active, m_id, m_last, m_ab, m_pv;
   logic [W-1:0] m_pos, m_tdest, m_dest;
   int           m_back_c, m_start_c, m_done_c, m_home_end, m_move_end;
   bit           e_take, e_id;
   int           c;
   int           n_back = 0, n_start = 0;

   task automatic m_reset();
      m_active = 0; m_id = 0; m_last = 1; m_ab = 0; m_pv = 0;
      m_pos = '0; m_tdest = '0; m_dest = '0;
      m_back_c = -1; m_start_c = -1; m_done_c = -1;
      m_home_end = -1; m_move_end = -1;
   endtask

   always @(negedge clk) begin
      if (rst) begin
         m_reset();
      end else begin
         c = cyc;
         e_take = !m_active && !abort && (req0 || req1);
         e_id = (req0 && req1) ? !m_last : req1;
         chk("ack0", ack0, e_take && !e_id);
         chk("ack1", ack1, e_take && e_id);
         chk("busy", busy, m_active);
         chk("table_back", table_back, c != m_back_c);
         chk("table_start", table_start, c != m_start_c);
         chk("done0", done0, m_active && c == m_done_c && !m_id);
         chk("done1", done1, m_active && c == m_done_c && m_id);
         chk("err", err, m_active && c == m_done_c && m_ab);
         chk("table_dest", table_dest, m_tdest);
         chk("pos", pos, m_pos);
         chk("pos_valid", pos_valid, m_pv);
         if (!table_back) n_back++;
         if (!table_start) n_start++;

         if (!m_active) begin
            if (abort) begin
               m_pv = 0;
            end else if (e_take) begin
               m_active = 1; m_id = e_id; m_last = e_id; m_ab = 0;
               m_dest = e_id ? dest1 : dest0;
               m_back_c = -1; m_start_c = -1;
               m_home_end = -1; m_move_end = -1;
               if ((e_id ? home1 : home0) || !m_pv) begin
                  m_back_c = c + 1;
                  m_home_end = c + H + 2;
                  if (m_dest == '0) begin
                     m_done_c = m_home_end;
                  end else begin
                     m_start_c = m_home_end;
                     m_move_end = m_start_c + M + 1;
                     m_done_c = m_move_end;
                  end
               end else if (m_dest == m_pos) begin
                  m_done_c = c + 1;
               end else begin
                  m_start_c = c + 1;
                  m_move_end = c + M + 2;
                  m_done_c = m_move_end;
               end
            end
         end else if (c == m_done_c) begin
            m_active = 0;
            m_ab = 0;
         end else if (abort && !m_ab) begin
            m_ab = 1;
            m_pv = 0;
            if (c != m_back_c) m_back_c = c + 1;
            m_home_end = m_back_c + H + 1;
            m_done_c = m_home_end;
            m_start_c = -1;
            m_move_end = -1;
         end
         if (c + 1 == m_home_end) begin
            m_pos = '0;
            m_pv = 1;
         end
         if (c + 1 == m_start_c) m_tdest = m_dest;
         if (c + 1 == m_move_end) begin
            m_pos = m_tdest;
            m_pv = 1;
         end
      end
   end

   function automatic bit sig(input int sel);
      case (sel)
         0: return ack0;
         1: return ack1;
         2: return ack0 || ack1;
         3: return done0 || done1;
         4: return !table_start;
         default: return !table_back;
      endcase
   endfunction

   task automatic wait_sig(input int sel, input int lim, output int at);
      at = -1;
      for (int i = 0; i < lim; i++) begin
         @(negedge clk);
         #1;
         if (sig(sel)) begin
            at = cyc;
            break;
         end
      end
      if (at < 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL wait_%0d: no event within %0d cycles, required one", sel, lim);
      end
   endtask

   task automatic request(input bit id, input logic [W-1:0] d, input bit h,
                          output int at);
      @(posedge clk);
      #1;
      if (id) begin
         req1 = 1; dest1 = d; home1 = h;
      end else begin
         req0 = 1; dest0 = d; home0 = h;
      end
      wait_sig(id ? 1 : 0, 50, at);
      @(posedge clk);
      #1;
      req0 = 0;
      req1 = 0;
   endtask

   int a, b, s, d, x, g, r, nb, ns;
   bit ids[4];
   bit exp_ids[4] = '{1'b1, 1'b0, 1'b1, 1'b0};

   initial begin
      repeat (3) @(negedge clk);
      rst = 0;
      @(negedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_start", table_start, 1);
      chk("rst_back", table_back, 1);
      chk("rst_pos_valid", pos_valid, 0);

      // first move from reset: homes, then moves to 100
      @(posedge clk);
      #1;
      r = cyc;
      req0 = 1; dest0 = 100; home0 = 0;
      wait_sig(0, 5, a);
      chk("t1_ack_cycle", a - r, 0);
      @(posedge clk);
      #1;
      req0 = 0;
      wait_sig(5, 5, b);
      chk("t1_ack_to_back", b - a, 1);
      wait_sig(4, 60, s);
      chk("t1_back_to_start", s - b, 21);
      chk("t1_start_dest", table_dest, 100);
      wait_sig(3, 80, d);
      chk("t1_start_to_done", d - s, 31);
      chk("t1_pos", pos, 100);
      chk("t1_pos_valid", pos_valid, 1);

      // both requesting in IDLE: grants alternate, last grant was 0
      @(posedge clk);
      #1;
      req0 = 1; req1 = 1; dest0 = 100; dest1 = 100;
      for (int k = 0; k < 4; k++) begin
         wait_sig(2, 20, a);
         g = ack1;
         ids[k] = g;
         @(posedge clk);
         #1;
         if (g) req1 = 0; else req0 = 0;
         wait_sig(3, 20, d);
         if (k < 3) begin
            @(posedge clk);
            #1;
            if (g) req1 = 1; else req0 = 1;
         end
      end
      @(posedge clk);
      #1;
      req0 = 0; req1 = 0;
      for (int k = 0; k < 4; k++) chk("rr_grant", ids[k], exp_ids[k]);

      // already at destination: no motion
      nb = n_back; ns = n_start;
      request(1, 100, 0, a);
      wait_sig(3, 10, d);
      chk("t3_ack_to_done", d - a, 1);
      chk("t3_done1", done1, 1);
      chk("t3_no_back", n_back - nb, 0);
      chk("t3_no_start", n_start - ns, 0);

      // abort during MOVE_WAIT of a move to 200
      request(0, 200, 0, a);
      wait_sig(4, 5, s);
      chk("t4_start", s - a, 1);
      repeat (5) @(posedge clk);
      #1;
      abort = 1;
      x = cyc;
      @(posedge clk);
      #1;
      abort = 0;
      @(negedge clk);
      #1;
      chk("t4_pv_cleared", pos_valid, 0);
      chk("t4_back_after_abort", table_back, 0);
      wait_sig(3, 60, d);
      chk("t4_back_to_done", d - (x + 1), 21);
      chk("t4_err", err, 1);
      chk("t4_pos", pos, 0);
      chk("t4_pos_valid", pos_valid, 1);

      // forced homing with dest 0 from a valid position of 100
      request(0, 100, 0, a);
      wait_sig(3, 60, d);
      chk("t5_pre_pos", pos, 100);
      ns = n_start;
      request(0, 0, 1, a);
      wait_sig(5, 5, b);
      chk("t5_back", b - a, 1);
      wait_sig(3, 60, d);
      chk("t5_back_to_done", d - b, 21);
      chk("t5_no_start", n_start - ns, 0);
      chk("t5_pos", pos, 0);
      chk("t5_err", err, 0);

      // abort in IDLE suppresses the grant
      @(posedge clk);
      #1;
      abort = 1; req0 = 1; dest0 = 30; home0 = 0;
      @(negedge clk);
      #1;
      chk("t6_no_ack", ack0, 0);
      @(posedge clk);
      #1;
      abort = 0;
      wait_sig(0, 5, a);
      @(posedge clk);
      #1;
      req0 = 0;
      wait_sig(5, 5, b);
      chk("t6_rehome", b - a, 1);

      // asynchronous reset during HOME_WAIT
      repeat (5) @(posedge clk);
      #3;
      rst = 1;
      #1;
      chk("t7_busy", busy, 0);
      chk("t7_back", table_back, 1);
      chk("t7_start", table_start, 1);
      chk("t7_tdest", table_dest, 0);
      chk("t7_pos", pos, 0);
      chk("t7_pos_valid", pos_valid, 0);
      chk("t7_done", done0, 0);
      @(posedge clk);
      #3;
      rst = 0;
      request(0, 40, 0, a);
      wait_sig(5, 5, b);
      chk("t7_rehome", b - a, 1);
      wait_sig(3, 80, d);
      chk("t7_pos_after", pos, 40);
      chk("t7_pv_after", pos_valid, 1);

      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
      $fatal(1, "watchdog");
   end

endmodule
